// File: rtl/sys_ctrl.sv
// sys_ctrl: byte-framed command controller between a serial RX/TX pair and
// a small register file.
//   AA <addr> <dlo> <dhi> -> one-cycle register-file write
//   BB <addr>             -> register-file read, result sent as two TX bytes
// Optional build macro SYS_CTRL_ERR_EN: flags unknown command bytes and
// out-of-range address bytes on Cmd_Err and aborts the offending frame.
module sys_ctrl #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 3,
    parameter int FRAME = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [FRAME-1:0] RX_P_Data,
    input  logic             RX_D_VLD,
    output logic [WIDTH-1:0] WrData,
    output logic [ADDR-1:0]  Address,
    output logic             WrEn,
    output logic             RdEn,
    input  logic [WIDTH-1:0] RdData,
    output logic [FRAME-1:0] TX_P_Data,
    output logic             TX_D_VLD,
    input  logic             TX_Busy,
    output logic             Cmd_Err
);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DLO, WR_DHI, WR_EXEC,
        RD_ADDR, RD_EXEC, RD_CAPT, TX_LO, TX_WAIT, TX_HI
    } state_t;

    localparam logic [FRAME-1:0] CMD_WR = FRAME'(8'hAA);
    localparam logic [FRAME-1:0] CMD_RD = FRAME'(8'hBB);

    state_t           state, nextState;
    logic [ADDR-1:0]  addrReg;
    logic [WIDTH-1:0] wrData;
    logic [WIDTH-1:0] hold;
    logic [FRAME-1:0] txData;   // last byte handed to the transmitter
    logic [FRAME-1:0] txByte;
    logic             sawBusy;  // TX_Busy observed high while in TX_WAIT
    logic             loadAddr, loadLo, loadHi;

`ifdef SYS_CTRL_ERR_EN
    logic errSet, errPulse;
    logic addrHigh;
    assign addrHigh = |RX_P_Data[FRAME-1:ADDR];
`endif

    // State register; reset drops any partial frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state decode and strobe outputs.
    always_comb begin
        nextState = state;
        WrEn      = 1'b0;
        RdEn      = 1'b0;
        TX_D_VLD  = 1'b0;
        txByte    = txData;
        loadAddr  = 1'b0;
        loadLo    = 1'b0;
        loadHi    = 1'b0;
`ifdef SYS_CTRL_ERR_EN
        errSet    = 1'b0;
`endif
        case (state)
            IDLE: if (RX_D_VLD) begin
                if (RX_P_Data == CMD_WR)      nextState = WR_ADDR;
                else if (RX_P_Data == CMD_RD) nextState = RD_ADDR;
`ifdef SYS_CTRL_ERR_EN
                else                          errSet = 1'b1;
`endif
            end
            WR_ADDR, RD_ADDR: if (RX_D_VLD) begin
`ifdef SYS_CTRL_ERR_EN
                if (addrHigh) begin
                    errSet    = 1'b1;
                    nextState = IDLE;
                end else
`endif
                begin
                    loadAddr  = 1'b1;
                    nextState = (state == WR_ADDR) ? WR_DLO : RD_EXEC;
                end
            end
            WR_DLO: if (RX_D_VLD) begin
                loadLo    = 1'b1;
                nextState = WR_DHI;
            end
            WR_DHI: if (RX_D_VLD) begin
                loadHi    = 1'b1;
                nextState = WR_EXEC;
            end
            WR_EXEC: begin
                WrEn      = 1'b1;
                nextState = IDLE;
            end
            RD_EXEC: begin
                RdEn      = 1'b1;
                nextState = RD_CAPT;
            end
            RD_CAPT: nextState = TX_LO;
            TX_LO: if (!TX_Busy) begin
                TX_D_VLD  = 1'b1;
                txByte    = hold[FRAME-1:0];
                nextState = TX_WAIT;
            end
            TX_WAIT: if (sawBusy && !TX_Busy) nextState = TX_HI;
            TX_HI: begin
                TX_D_VLD  = 1'b1;
                txByte    = FRAME'(hold >> FRAME);
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Frame datapath: address/data capture, read hold, TX byte memory.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addrReg <= '0;
            wrData  <= '0;
            hold    <= '0;
            txData  <= '0;
            sawBusy <= 1'b0;
        end else begin
            if (loadAddr) addrReg <= RX_P_Data[ADDR-1:0];
            if (loadLo)   wrData[FRAME-1:0] <= RX_P_Data;
            if (loadHi)   wrData[WIDTH-1:FRAME] <= RX_P_Data[WIDTH-FRAME-1:0];
            if (state == RD_CAPT) hold <= RdData;
            if (TX_D_VLD) txData <= txByte;
            sawBusy <= (state == TX_WAIT) ? (sawBusy | TX_Busy) : 1'b0;
        end
    end

`ifdef SYS_CTRL_ERR_EN
    // Registered one-cycle error pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) errPulse <= 1'b0;
        else      errPulse <= errSet;
    end
    assign Cmd_Err = errPulse;
`else
    assign Cmd_Err = 1'b0;
`endif

    assign Address   = addrReg;
    assign WrData    = wrData;
    assign TX_P_Data = txByte;

endmodule

// File: tb/tb_sys_ctrl.sv
// Testbench for sys_ctrl: directed byte frames, register-file and
// transmitter models, scoreboard queues for writes, reads and TX bytes.
module tb_sys_ctrl;
    localparam int WIDTH = 16;
    localparam int ADDR  = 3;
    localparam int FRAME = 8;
`ifdef SYS_CTRL_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic             CLK_tb = 1'b0;
    logic             RST;
    logic [FRAME-1:0] RX_P_Data;
    logic             RX_D_VLD;
    logic [WIDTH-1:0] WrData;
    logic [ADDR-1:0]  Address;
    logic             WrEn, RdEn;
    logic [WIDTH-1:0] RdData;
    logic [FRAME-1:0] TX_P_Data;
    logic             TX_D_VLD;
    logic             TX_Busy;
    logic             Cmd_Err;

    int errors = 0;
    int checks = 0;
    int wrCnt = 0, rdCnt = 0, txCnt = 0;

    logic [ADDR+WIDTH-1:0] wrQ[$];
    logic [ADDR-1:0]       rdQ[$];
    logic [FRAME-1:0]      txQ[$];

    logic [WIDTH-1:0] mem [8];
    logic             forceBusy;
    int               busyCnt = 0;

    sys_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .FRAME(FRAME)) dut (
        .CLK(CLK_tb), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
        .WrData(WrData), .Address(Address), .WrEn(WrEn), .RdEn(RdEn),
        .RdData(RdData), .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD),
        .TX_Busy(TX_Busy), .Cmd_Err(Cmd_Err)
    );

    always #5 CLK_tb = ~CLK_tb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Register file: write on WrEn, read data one cycle after RdEn.
    always @(posedge CLK_tb) begin
        if (WrEn) mem[Address] <= WrData;
        if (RdEn) RdData <= mem[Address];
    end

    // Transmitter: busy for 3 cycles after each accepted byte.
    always @(posedge CLK_tb) begin
        if (TX_D_VLD)         busyCnt <= 3;
        else if (busyCnt > 0) busyCnt <= busyCnt - 1;
    end
    assign TX_Busy = forceBusy | (busyCnt != 0);

    // Output monitor: strobes are checked against the scoreboard queues.
    always @(negedge CLK_tb) begin
        chk("wr_rd_exclusive", {31'd0, WrEn & RdEn}, 32'd0);
        if (WrEn) begin
            wrCnt++;
            if (wrQ.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
            else chk("wr_addr_data", {13'd0, Address, WrData}, {13'd0, wrQ.pop_front()});
        end
        if (RdEn) begin
            rdCnt++;
            if (rdQ.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
            else chk("rd_addr", {29'd0, Address}, {29'd0, rdQ.pop_front()});
        end
        if (TX_D_VLD) begin
            txCnt++;
            if (txQ.size() == 0) chk("unexpected_tx", 32'd1, 32'd0);
            else chk("tx_byte", {24'd0, TX_P_Data}, {24'd0, txQ.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_tb);
        #1;
    endtask

    // One-cycle RX pulse; returns #1 after the edge that consumed the byte.
    task automatic sendByte(input logic [FRAME-1:0] b);
        RX_P_Data = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK_tb);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic waitTx(input int target, input string tag);
        int n;
        n = 0;
        while (txCnt < target && n < 100) begin
            tick(1);
            n++;
        end
        chk(tag, txCnt, target);
    endtask

    initial begin
        int wr0, rd0, tx0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        RST = 1'b0; RX_D_VLD = 1'b0; RX_P_Data = '0; forceBusy = 1'b0;
        tick(2);
        chk("rst_outputs", {WrEn, RdEn, TX_D_VLD, Cmd_Err, Address, WrData, TX_P_Data},
            32'd0);
        RST = 1'b1;
        tick(1);

        // Write 0x1234 to address 3; WrEn one cycle after the last byte.
        wrQ.push_back({3'd3, 16'h1234});
        sendByte(8'hAA); sendByte(8'h03); sendByte(8'h34); sendByte(8'h12);
        chk("wr_latency_wren", {31'd0, WrEn}, 32'd1);
        chk("wr_address", {29'd0, Address}, 32'd3);
        chk("wr_data", {16'd0, WrData}, 32'h1234);
        tick(1);
        chk("wren_one_cycle", {31'd0, WrEn}, 32'd0);

        // Read it back with an idle transmitter.
        rdQ.push_back(3'd3); txQ.push_back(8'h34); txQ.push_back(8'h12);
        tx0 = txCnt;
        sendByte(8'hBB); sendByte(8'h03);
        chk("rden_in_rd_exec", {31'd0, RdEn}, 32'd1);
        tick(1);
        chk("rden_one_cycle", {31'd0, RdEn}, 32'd0);
        waitTx(tx0 + 2, "read_tx_count");
        tick(6);

        // Preload address 2 with 0xBEEF.
        wrQ.push_back({3'd2, 16'hBEEF});
        sendByte(8'hAA); sendByte(8'h02); sendByte(8'hEF); sendByte(8'hBE);
        tick(2);

        // Transmitter busy for 20 cycles: TX held off, nothing lost.
        forceBusy = 1'b1;
        rdQ.push_back(3'd3); txQ.push_back(8'h34); txQ.push_back(8'h12);
        tx0 = txCnt;
        sendByte(8'hBB); sendByte(8'h03);
        tick(20);
        chk("tx_withheld_busy", txCnt, tx0);
        forceBusy = 1'b0;
        waitTx(tx0 + 2, "busy_read_tx_count");
        tick(6);

        // Unknown command byte.
        wr0 = wrCnt; rd0 = rdCnt;
        sendByte(8'h55);
        chk("unknown_cmd_err", {31'd0, Cmd_Err}, {31'd0, ERR_EXP});
        tick(1);
        chk("cmd_err_one_cycle", {31'd0, Cmd_Err}, 32'd0);
        tick(2);
        chk("unknown_no_wr", wrCnt, wr0);
        chk("unknown_no_rd", rdCnt, rd0);

        // Out-of-range address byte 0x0B.
`ifdef SYS_CTRL_ERR_EN
        wr0 = wrCnt;
        sendByte(8'hAA); sendByte(8'h0B);
        chk("bad_addr_err", {31'd0, Cmd_Err}, 32'd1);
        tick(3);
        chk("bad_addr_no_wr", wrCnt, wr0);
        wrQ.push_back({3'd5, 16'h0A0B});
        sendByte(8'hAA); sendByte(8'h05); sendByte(8'h0B); sendByte(8'h0A);
        chk("after_abort_wren", {31'd0, WrEn}, 32'd1);
`else
        wrQ.push_back({3'd3, 16'h5678});
        sendByte(8'hAA); sendByte(8'h0B);
        chk("trunc_addr", {29'd0, Address}, 32'd3);
        chk("trunc_no_err", {31'd0, Cmd_Err}, 32'd0);
        sendByte(8'h78); sendByte(8'h56);
        chk("trunc_wren", {31'd0, WrEn}, 32'd1);
`endif
        tick(2);

        // Reset mid-frame, then a clean read of address 2.
        wr0 = wrCnt;
        sendByte(8'hAA); sendByte(8'h02);
        chk("midframe_addr", {29'd0, Address}, 32'd2);
        RST = 1'b0;
        #1;
        chk("async_rst_outputs",
            {WrEn, RdEn, TX_D_VLD, Cmd_Err, Address, WrData, TX_P_Data}, 32'd0);
        tick(1);
        RST = 1'b1;
        tick(1);
        rdQ.push_back(3'd2); txQ.push_back(8'hEF); txQ.push_back(8'hBE);
        tx0 = txCnt;
        sendByte(8'hBB); sendByte(8'h02);
        waitTx(tx0 + 2, "post_rst_read_tx");
        tick(6);
        chk("no_stale_write", wrCnt, wr0);

        chk("wrQ_empty", wrQ.size(), 0);
        chk("rdQ_empty", rdQ.size(), 0);
        chk("txQ_empty", txQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register-file data width.
REQ-002 SHALL have parameter ADDR, default 3, register-file address width (8 entries).
REQ-003 SHALL have parameter FRAME, default 8, width of a received or transmitted byte.
REQ-004 SHALL have port CLK  input  1  single system clock, rising-edge active.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port RX_P_Data  input  FRAME  received byte from the serial receiver.
REQ-007 SHALL have port RX_D_VLD  input  1  one-cycle pulse, RX_P_Data valid.
REQ-008 SHALL have port WrData  output  WIDTH  register-file write data.
REQ-009 SHALL have port Address  output  ADDR  register-file address.
REQ-010 SHALL have port WrEn  output  1  register-file write enable.
REQ-011 SHALL have port RdEn  output  1  register-file read enable.
REQ-012 SHALL have port RdData  input  WIDTH  register-file read data, valid the cycle after RdEn.
REQ-013 SHALL have port TX_P_Data  output  FRAME  byte to the serial transmitter.
REQ-014 SHALL have port TX_D_VLD  output  1  one-cycle pulse, TX_P_Data valid.
REQ-015 SHALL have port TX_Busy  input  1  transmitter busy.
REQ-016 SHALL have port Cmd_Err  output  1  one-cycle error pulse.

Function
REQ-017 SHALL implement the states IDLE, WR_ADDR, WR_DLO, WR_DHI, WR_EXEC, RD_ADDR, RD_EXEC, RD_CAPT, TX_LO, TX_WAIT and TX_HI.
REQ-018 SHALL, in IDLE, on RX_D_VLD, go to WR_ADDR for byte 0xAA, go to RD_ADDR for byte 0xBB, and otherwise ignore the byte and stay in IDLE.
REQ-019 SHALL, in WR_ADDR, WR_DLO and WR_DHI, each consume one RX_D_VLD byte: the address byte (low ADDR bits kept), then data[7:0], then data[15:8], stalling indefinitely between bytes.
REQ-020 SHALL, in WR_EXEC, drive WrEn=1 for exactly one cycle with the Address and WrData latched from the frame, then return to IDLE.
REQ-021 SHALL, in RD_ADDR, consume one address byte, and in RD_EXEC drive RdEn=1 for exactly one cycle.
REQ-022 SHALL, in RD_CAPT, latch RdData (the cycle after RdEn) into an internal WIDTH-bit holding register.
REQ-023 SHALL, in TX_LO, wait for TX_Busy=0, then pulse TX_D_VLD for one cycle with TX_P_Data=hold[7:0].
REQ-024 SHALL, in TX_WAIT, wait until TX_Busy has been seen at 1 and then at 0.
REQ-025 SHALL, in TX_HI, pulse TX_D_VLD for one cycle with TX_P_Data=hold[15:8], then return to IDLE.
REQ-026 SHALL ignore RX_D_VLD in RD_EXEC, RD_CAPT, TX_LO, TX_WAIT, TX_HI and WR_EXEC (bytes dropped, no buffering).
REQ-027 SHALL keep WrEn, RdEn and TX_D_VLD at 0 outside their stated states.
REQ-028 SHALL hold Address, WrData and TX_P_Data at their last values when not in use.
REQ-029 SHALL keep WrEn and RdEn mutually exclusive in every cycle.
REQ-030 SHALL complete a write with latency of exactly 1 cycle from the RX_D_VLD cycle of the last data byte to WrEn.

Reset
REQ-031 SHALL, on RST=0, asynchronously enter IDLE and force WrEn, RdEn, TX_D_VLD and Cmd_Err to 0 and Address, WrData, TX_P_Data and the holding register to 0.
REQ-032 SHALL abandon any partial frame on reset mid-command; after release the next byte is treated as a command byte.

Configuration
REQ-033 SHALL, with SYS_CTRL_ERR_EN defined: pulse Cmd_Err for one cycle on an unknown command byte in IDLE or on an address byte with any bit above ADDR-1 set; an offending address byte aborts the frame to IDLE with no WrEn/RdEn.
REQ-034 SHALL, without SYS_CTRL_ERR_EN: tie Cmd_Err to 0 and truncate address bytes to ADDR bits with no abort.

Verification
REQ-035 SHALL cover: bytes AA,03,34,12 -> one-cycle WrEn, Address=3, WrData=0x1234, one cycle after the 0x12 pulse.
REQ-036 SHALL cover: after REQ-035, bytes BB,03 with TX_Busy idle -> RdEn for one cycle, then TX bytes 0x34 then 0x12, each a one-cycle TX_D_VLD.
REQ-037 SHALL cover: TX_Busy held 1 for 20 cycles during a read -> TX_D_VLD withheld until TX_Busy=0, with no byte lost or duplicated.
REQ-038 SHALL cover: byte 0x55 in IDLE -> no WrEn/RdEn, Cmd_Err pulse with SYS_CTRL_ERR_EN and Cmd_Err=0 without it.
REQ-039 SHALL cover: bytes AA,0B with SYS_CTRL_ERR_EN -> Cmd_Err pulse and return to IDLE; without it, the frame proceeds to Address=3.
REQ-040 SHALL cover: RST=0 after AA,02 -> all outputs 0; then BB,02 -> a normal read, showing no stale write.
